hwpe_stream_sink_realign: RTL
=============================

# hwpe_stream_sink_realign

Write-side counterpart of the source-side realigner. It takes a word-aligned HWPE stream from the engine and rotates it onto an arbitrary byte offset in memory. It regenerates per-byte write strobes and emits one trailing flush beat when the final bytes spill into the next word. It sits between the engine output stream and the TCDM sink/streamer that issues the memory writes.

## Interface
- DATA_WIDTH, 32, stream data width in bits; multiple of 8; NB = DATA_WIDTH/8 bytes, OW = $clog2(NB).
- clk_gated  input  1  clock, already gated by the parent.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous soft clear.
- realign_i  input  1  1 = realign the transfer; 0 = pure pass-through.
- first_i  input  1  the current input beat is the first of a transfer.
- last_i  input  1  the current input beat is the last of a transfer.
- offset_i  input  OW  byte offset o of the destination address; sampled on the first beat.
- stream_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  aligned input: data, strb, valid, ready.
- stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH  misaligned output with write strobes.

## Operation
- States: START, STREAM, FLUSH.
- Registers:
  - state_q, reset START.
  - prev_data_q, reset 0.
  - prev_strb_q, reset 0.
  - offset_q, reset 0.
- Effective offset o = offset_i when state_q == START, otherwise offset_q.
- Pass-through when realign_i = 0 or o = 0:
  - stream_o.data/strb/valid = stream_i.data/strb/valid.
  - stream_i.ready = stream_o.ready.
  - state_q stays START; no flush beat is ever produced.
- START and STREAM datapath (realign_i = 1, o ≠ 0):
  - stream_o.data = (stream_i.data << 8·o) | (prev_data_q >> 8·(NB−o)).
  - stream_o.strb = (stream_i.strb << o) | (prev_strb_q >> (NB−o)), truncated to NB bits.
  - In START, the prev terms count as 0 regardless of register contents.
  - stream_o.valid = stream_i.valid.
  - stream_i.ready = stream_o.ready.
- On an accepted input beat (valid & ready):
  - prev_data_q ← stream_i.data; prev_strb_q ← stream_i.strb.
  - In START: offset_q ← offset_i.
- Transitions on an accepted beat:
  - START → STREAM when first_i & ~last_i.
  - START/STREAM → FLUSH when last_i and (stream_i.strb >> (NB−o)) ≠ 0.
  - START/STREAM → START when last_i and the spill is 0.
- FLUSH datapath:
  - stream_o.data = prev_data_q >> 8·(NB−o).
  - stream_o.strb = prev_strb_q >> (NB−o).
  - stream_o.valid = 1; stream_i.ready = 0.
  - On stream_o.ready: state_q → START, and prev_data_q/prev_strb_q → 0.
- A first_i beat received while in STREAM is treated as a continuation; first_i is only decoded in START.
- clear_i takes priority over every other update: all registers return to their reset values and state_q → START. The combinational outputs of that cycle are still driven normally.
- Unlike the read-side realigner, no input beat is ever dropped. Output beats = input beats + (1 if a spill exists).

## Timing
- Zero-cycle latency: data, strb and valid are combinational from the inputs and registers. The only added cycle is the single FLUSH beat.
- In START/STREAM, ready propagates combinationally from stream_o to stream_i. In FLUSH, stream_i.ready is 0 independent of stream_o.ready.
- Valid/data stability under backpressure:
  - START/STREAM: stream_o.data/strb stay stable as long as stream_i.data/strb stay stable.
  - FLUSH: the outputs depend only on registers and stay stable until accepted.
- After reset, outputs mirror stream_i. stream_o.valid = stream_i.valid, with strb = stream_i.strb << offset_i when realigning.
- Reset or clear mid-transfer discards pending spill bytes; no flush beat is emitted for the aborted transfer.
- Back-to-back transfers: a first_i beat may be accepted in the cycle right after the FLUSH handshake.

## Test plan
All scenarios use DATA_WIDTH = 32 unless stated otherwise.
- **Pass-through.** realign_i = 0, beats 0xAABBCCDD and 0x11223344 with strb 0xF, last on the second. Output must be identical beats and strobes, with no third beat.
- **Three-beat spill, o = 1.** Beats 0x03020100, 0x07060504, 0x0B0A0908 with strb 0xF; last on beat 3. Required output:
  - 0x02010000 strb 0xE
  - 0x06050403 strb 0xF
  - 0x0A090807 strb 0xF
  - flush 0x0000000B strb 0x1
- **Single beat, o = 3.** One beat, first & last, data 0x44332211 strb 0xF. Required output: 0x11000000 strb 0x8, then flush 0x00443322 strb 0x7, then state START.
- **Partial last word, no flush.** o = 1, last beat has strb 0x3. Its output strb is 0x6 (plus any prev spill), and no FLUSH beat follows.
- **FLUSH backpressure.** o = 2, stream_o.ready held low for 3 cycles while in FLUSH. The flush beat must stay constant and stream_i.ready must be 0. A single transfer follows when ready rises, and the next first beat is accepted the cycle after.
- **Clear mid-transfer.** clear_i pulsed in STREAM after two beats at o = 1. Next, a transfer at o = 2 with first beat 0xDDCCBBAA strb 0xF. Required output: 0xBBAA0000 strb 0xC, with no leftover bytes.

Source files
------------

// File: rtl/hwpe_stream_sink_realign_if.sv
// HWPE stream handshake bundle: data with per-byte strobes, valid/ready flow control.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    valid;
    logic                    ready;

    modport source (output data, strb, valid, input  ready);
    modport sink   (input  data, strb, valid, output ready);
endinterface

// File: rtl/hwpe_stream_sink_realign.sv
// Write-side realigner: rotates a word-aligned stream onto a byte offset, regenerating
// write strobes and appending one flush beat when the tail spills into the next word.
module hwpe_stream_sink_realign #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                clk_gated,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                realign_i,
    input  logic                                first_i,
    input  logic                                last_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]     offset_i,
    hwpe_stream_intf_stream.sink                stream_i,
    hwpe_stream_intf_stream.source              stream_o
);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [1:0] {START, STREAM, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] prev_data_q, prev_data_d;
    logic [NB-1:0]         prev_strb_q, prev_strb_d;
    logic [OW-1:0]         offset_q, offset_d;

    logic [OW-1:0]         off;
    logic [OW:0]           rsh;
    logic                  passthru, in_hs, spill;
    logic [DATA_WIDTH-1:0] prev_data_m;
    logic [NB-1:0]         prev_strb_m;

    always_comb begin
        off         = (state_q == START) ? offset_i : offset_q;
        rsh         = (OW+1)'(NB) - {1'b0, off};
        passthru    = ~realign_i | (off == '0);
        // The carried-over tail only exists once a transfer is under way.
        prev_data_m = (state_q == START) ? '0 : (prev_data_q >> {rsh, 3'b000});
        prev_strb_m = (state_q == START) ? '0 : (prev_strb_q >> rsh);
        spill       = (stream_i.strb >> rsh) != '0;
        in_hs       = stream_i.valid & stream_o.ready & (state_q != FLUSH);

        stream_o.data  = stream_i.data;
        stream_o.strb  = stream_i.strb;
        stream_o.valid = stream_i.valid;
        stream_i.ready = stream_o.ready;
        state_d        = state_q;
        prev_data_d    = prev_data_q;
        prev_strb_d    = prev_strb_q;
        offset_d       = offset_q;

        if (state_q == FLUSH) begin
            stream_o.data  = prev_data_q >> {rsh, 3'b000};
            stream_o.strb  = prev_strb_q >> rsh;
            stream_o.valid = 1'b1;
            stream_i.ready = 1'b0;
            if (stream_o.ready) begin
                state_d     = START;
                prev_data_d = '0;
                prev_strb_d = '0;
            end
        end else begin
            if (!passthru) begin
                stream_o.data = (stream_i.data << {off, 3'b000}) | prev_data_m;
                stream_o.strb = (stream_i.strb << off) | prev_strb_m;
            end
            if (in_hs) begin
                prev_data_d = stream_i.data;
                prev_strb_d = stream_i.strb;
                if (state_q == START) offset_d = offset_i;
                if (last_i)
                    state_d = (!passthru && spill) ? FLUSH : START;
                else if (!passthru && state_q == START && first_i)
                    state_d = STREAM;
            end
        end
    end

    always_ff @(posedge clk_gated or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= START;
            prev_data_q <= '0;
            prev_strb_q <= '0;
            offset_q    <= '0;
        end else if (clear_i) begin
            state_q     <= START;
            prev_data_q <= '0;
            prev_strb_q <= '0;
            offset_q    <= '0;
        end else begin
            state_q     <= state_d;
            prev_data_q <= prev_data_d;
            prev_strb_q <= prev_strb_d;
            offset_q    <= offset_d;
        end
    end
endmodule
